// File: rtl/stage_sequencer.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer with memory-wait timeout.
// Optional single-step control is enabled by defining STAGE_SEQUENCER_SINGLE_STEP_EN.
module stage_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Run,
    input  logic                   MFC,
    input  logic                   Mem_Access,
    input  logic                   Halt_Instr,
`ifdef STAGE_SEQUENCER_SINGLE_STEP_EN
    input  logic                   Step_Mode,
    input  logic                   Step,
`endif
    output logic [2:0]             Stage,
    output logic                   Stall,
    output logic                   Halted,
    output logic                   Fault,
    output logic [COUNT_WIDTH-1:0] Instr_Count
);

    localparam int unsigned WAIT_WIDTH = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALTED    = 3'd6
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [2:0]             stage_r;
    logic                   halted_r;
    logic                   fault_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [WAIT_WIDTH-1:0]  wait_r;
    logic                   stall_s;
    logic                   timeout_s;
    logic                   retire_s;
    logic                   start_s;
    logic                   step_hold_s;

    function automatic logic [2:0] stage_code(input state_t s);
        case (s)
            ST_FETCH:     stage_code = 3'd1;
            ST_DECODE:    stage_code = 3'd2;
            ST_EXECUTE:   stage_code = 3'd3;
            ST_MEMORY:    stage_code = 3'd4;
            ST_WRITEBACK: stage_code = 3'd5;
            default:      stage_code = 3'd0;
        endcase
    endfunction

`ifdef STAGE_SEQUENCER_SINGLE_STEP_EN
    // In step mode a Step pulse is only honoured while idle.
    assign start_s     = Run & (~Step_Mode | Step);
    assign step_hold_s = Step_Mode;
`else
    assign start_s     = Run;
    assign step_hold_s = 1'b0;
`endif

    // Next-state, stall and timeout decode.
    always_comb begin
        next_state_s = state_r;
        stall_s      = 1'b0;
        timeout_s    = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) next_state_s = ST_FETCH;
                else         next_state_s = ST_IDLE;
            end
            ST_FETCH, ST_MEMORY: begin
                // Memory without an access skips the wait entirely.
                if ((state_r == ST_MEMORY) && !Mem_Access) begin
                    next_state_s = ST_WRITEBACK;
                end else if (MFC) begin
                    next_state_s = (state_r == ST_FETCH) ? ST_DECODE : ST_WRITEBACK;
                end else begin
                    stall_s = 1'b1;
                    if (wait_r == WAIT_LAST) begin
                        timeout_s    = 1'b1;
                        next_state_s = ST_HALTED;
                    end else begin
                        next_state_s = state_r;
                    end
                end
            end
            ST_DECODE: begin
                if (Halt_Instr) next_state_s = ST_HALTED;
                else            next_state_s = ST_EXECUTE;
            end
            ST_EXECUTE: next_state_s = ST_MEMORY;
            ST_WRITEBACK: begin
                retire_s = 1'b1;
                if (Run && !step_hold_s) next_state_s = ST_FETCH;
                else                     next_state_s = ST_IDLE;
            end
            ST_HALTED: begin
                if (!fault_r && Run) next_state_s = ST_FETCH;
                else                 next_state_s = ST_HALTED;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, registered outputs, retire counter and wait counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            stage_r  <= 3'd0;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
            count_r  <= '0;
            wait_r   <= '0;
        end else begin
            state_r  <= next_state_s;
            stage_r  <= stage_code(next_state_s);
            halted_r <= (next_state_s == ST_HALTED);
            fault_r  <= fault_r | timeout_s;
            if (retire_s) count_r <= count_r + COUNT_WIDTH'(1'b1);
            else          count_r <= count_r;
            // Any non-stalled cycle restarts the wait, so each wait begins at zero.
            if (stall_s && !timeout_s) wait_r <= wait_r + WAIT_WIDTH'(1'b1);
            else                       wait_r <= '0;
        end
    end

    assign Stage       = stage_r;
    assign Stall       = stall_s;
    assign Halted      = halted_r;
    assign Fault       = fault_r;
    assign Instr_Count = count_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: per-cycle expected outputs are queued when
// stimulus is driven and compared when the outputs are sampled on the falling edge.
module tb_stage_sequencer;

    typedef struct packed {
        logic [2:0]  stage;
        logic        stall;
        logic        halted;
        logic        fault;
        logic [15:0] count;
    } obs_t;

    logic        Clock;
    logic        Reset;
    logic        Run;
    logic        MFC;
    logic        Mem_Access;
    logic        Halt_Instr;
    logic [2:0]  Stage;
    logic        Stall;
    logic        Halted;
    logic        Fault;
    logic [15:0] Instr_Count;
`ifdef STAGE_SEQUENCER_SINGLE_STEP_EN
    logic        Step_Mode;
    logic        Step;
`endif

    obs_t obs_s;
    obs_t exp_q[$];
    int   errors;
    int   checks;

    stage_sequencer #(.MEM_TIMEOUT(16), .COUNT_WIDTH(16)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Run         (Run),
        .MFC         (MFC),
        .Mem_Access  (Mem_Access),
        .Halt_Instr  (Halt_Instr),
`ifdef STAGE_SEQUENCER_SINGLE_STEP_EN
        .Step_Mode   (Step_Mode),
        .Step        (Step),
`endif
        .Stage       (Stage),
        .Stall       (Stall),
        .Halted      (Halted),
        .Fault       (Fault),
        .Instr_Count (Instr_Count)
    );

    assign obs_s = {Stage, Stall, Halted, Fault, Instr_Count};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic string fmt(input obs_t v);
        return $sformatf("stage=%0d stall=%0b halted=%0b fault=%0b count=%0d",
                         v.stage, v.stall, v.halted, v.fault, v.count);
    endfunction

    function automatic obs_t mk(input int stage, input bit stall, input bit halted,
                                input bit fault, input int count);
        obs_t v;
        v.stage  = 3'(stage);
        v.stall  = stall;
        v.halted = halted;
        v.fault  = fault;
        v.count  = 16'(count);
        return v;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic run, input logic mfc, input logic mem, input logic halt);
        Run        = run;
        MFC        = mfc;
        Mem_Access = mem;
        Halt_Instr = halt;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t want;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 0));
            @(negedge Clock);
            want = exp_q.pop_front();
            checks++;
            if (obs_s !== want) begin
                errors++;
                $display("FAIL reset cyc %0d: got %s, want %s", i, fmt(obs_s), fmt(want));
            end
            tick();
        end
        Reset = 1'b0;
    endtask

    task automatic test_free_run();
        obs_t want;
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            exp_q.push_back(mk((i == 0) ? 0 : ((i - 1) % 5) + 1, 1'b0, 1'b0, 1'b0,
                               (i == 0) ? 0 : (i - 1) / 5));
            @(negedge Clock);
            want = exp_q.pop_front();
            checks++;
            if (obs_s !== want) begin
                errors++;
                $display("FAIL free_run cyc %0d: got %s, want %s", i, fmt(obs_s), fmt(want));
            end
            tick();
        end
    endtask

    task automatic test_fetch_stall();
        obs_t want;
        logic mfc_tab [0:9];
        int   st_tab  [0:9];
        mfc_tab = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        st_tab  = '{0, 1, 1, 1, 1, 2, 3, 4, 5, 1};
        do_reset();
        for (int i = 0; i <= 9; i++) begin
            // Cycle 7 is MEMORY without access: MFC low must not stall.
            drive(1'b1, mfc_tab[i], 1'b0, 1'b0);
            exp_q.push_back(mk(st_tab[i], (i >= 1 && i <= 3), 1'b0, 1'b0, (i == 9) ? 1 : 0));
            @(negedge Clock);
            want = exp_q.pop_front();
            checks++;
            if (obs_s !== want) begin
                errors++;
                $display("FAIL fetch_stall cyc %0d: got %s, want %s", i, fmt(obs_s), fmt(want));
            end
            tick();
        end
    endtask

    task automatic test_mem_timeout();
        obs_t want;
        int   st;
        logic mfc;
        do_reset();
        for (int i = 0; i <= 26; i++) begin
            // Two fetch stalls first, then MEMORY from cycle 6 with MFC stuck low.
            mfc = !((i == 1) || (i == 2) || (i >= 6));
            if (i == 0)      st = 0;
            else if (i <= 3) st = 1;
            else if (i <= 5) st = i - 2;
            else if (i <= 21) st = 4;
            else             st = 0;
            drive(1'b1, mfc, 1'b1, 1'b0);
            exp_q.push_back(mk(st, (i == 1) || (i == 2) || (i >= 6 && i <= 21),
                               i >= 22, i >= 22, 0));
            @(negedge Clock);
            want = exp_q.pop_front();
            checks++;
            if (obs_s !== want) begin
                errors++;
                $display("FAIL mem_timeout cyc %0d: got %s, want %s", i, fmt(obs_s), fmt(want));
            end
            tick();
        end
    endtask

    task automatic test_timeout_boundary();
        obs_t want;
        int   st;
        do_reset();
        for (int i = 0; i <= 21; i++) begin
            // 15 stalled fetch cycles, MFC arrives on the 16th (timeout) cycle.
            if (i == 0)       st = 0;
            else if (i <= 16) st = 1;
            else if (i <= 20) st = i - 15;
            else              st = 1;
            drive(1'b1, !(i >= 1 && i <= 15), 1'b0, 1'b0);
            exp_q.push_back(mk(st, (i >= 1 && i <= 15), 1'b0, 1'b0, (i == 21) ? 1 : 0));
            @(negedge Clock);
            want = exp_q.pop_front();
            checks++;
            if (obs_s !== want) begin
                errors++;
                $display("FAIL timeout_boundary cyc %0d: got %s, want %s", i, fmt(obs_s), fmt(want));
            end
            tick();
        end
    endtask

    task automatic test_halt();
        obs_t want;
        int   st;
        int   cnt;
        do_reset();
        for (int i = 0; i <= 18; i++) begin
            if (i == 0)       st = 0;
            else if (i <= 12) st = ((i - 1) % 5) + 1;
            else if (i <= 16) st = 0;
            else              st = i - 16;
            cnt = (i <= 5) ? 0 : ((i <= 10) ? 1 : 2);
            drive((i <= 12) || (i >= 16), 1'b1, 1'b0, (i == 11) || (i == 12));
            exp_q.push_back(mk(st, 1'b0, (i >= 13 && i <= 16), 1'b0, cnt));
            @(negedge Clock);
            want = exp_q.pop_front();
            checks++;
            if (obs_s !== want) begin
                errors++;
                $display("FAIL halt cyc %0d: got %s, want %s", i, fmt(obs_s), fmt(want));
            end
            tick();
        end
    endtask

    task automatic test_run_drop();
        obs_t want;
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            drive(i <= 2, 1'b1, 1'b0, 1'b0);
            exp_q.push_back(mk((i <= 5) ? i : 0, 1'b0, 1'b0, 1'b0, (i >= 6) ? 1 : 0));
            @(negedge Clock);
            want = exp_q.pop_front();
            checks++;
            if (obs_s !== want) begin
                errors++;
                $display("FAIL run_drop cyc %0d: got %s, want %s", i, fmt(obs_s), fmt(want));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t want;
        int   st_tab [0:12];
        st_tab = '{0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 4, 0, 1};
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            Reset = (i == 10);
            drive(1'b1, !(i == 9 || i == 10), 1'b1, 1'b0);
            exp_q.push_back(mk(st_tab[i], (i == 9 || i == 10), 1'b0, 1'b0,
                               (i >= 6 && i <= 10) ? 1 : 0));
            @(negedge Clock);
            want = exp_q.pop_front();
            checks++;
            if (obs_s !== want) begin
                errors++;
                $display("FAIL reset_mid_stall cyc %0d: got %s, want %s", i, fmt(obs_s), fmt(want));
            end
            tick();
        end
        Reset = 1'b0;
    endtask

`ifdef STAGE_SEQUENCER_SINGLE_STEP_EN
    task automatic test_single_step();
        obs_t want;
        int   st;
        do_reset();
        Step_Mode = 1'b1;
        for (int i = 0; i <= 29; i++) begin
            // Pulse at 4 lands mid-instruction and must be ignored.
            Step = (i == 1) || (i == 4) || (i == 21);
            if (i >= 2 && i <= 6)        st = i - 1;
            else if (i >= 22 && i <= 26) st = i - 21;
            else                         st = 0;
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            exp_q.push_back(mk(st, 1'b0, 1'b0, 1'b0, (i >= 27) ? 2 : ((i >= 7) ? 1 : 0)));
            @(negedge Clock);
            want = exp_q.pop_front();
            checks++;
            if (obs_s !== want) begin
                errors++;
                $display("FAIL single_step cyc %0d: got %s, want %s", i, fmt(obs_s), fmt(want));
            end
            tick();
        end
        Step      = 1'b0;
        Step_Mode = 1'b0;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        Reset  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef STAGE_SEQUENCER_SINGLE_STEP_EN
        Step_Mode = 1'b0;
        Step      = 1'b0;
`endif
        tick();
        test_reset();
        test_free_run();
        test_fetch_stall();
        test_mem_timeout();
        test_timeout_boundary();
        test_halt();
        test_run_drop();
        test_reset_mid_stall();
`ifdef STAGE_SEQUENCER_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
